// File: rtl/rom_dma_batch_sched.sv
// Walks rom_dma_ctrl through a table of {base, len} batch descriptors.
// Optional per-batch watchdog: define ROM_DMA_SCHED_TIMEOUT_EN.
module rom_dma_batch_sched #(
  parameter int ROM_ADDR_WIDTH = 16,
  parameter int NUM_DESC       = 8,
  parameter int DESC_IDX_W     = $clog2(NUM_DESC),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      desc_wr_en,
  input  logic [DESC_IDX_W-1:0]     desc_wr_idx,
  input  logic [ROM_ADDR_WIDTH-1:0] desc_wr_base,
  input  logic [ROM_ADDR_WIDTH-1:0] desc_wr_len,
  input  logic                      sched_start,
  input  logic [DESC_IDX_W:0]       sched_num_batches,
  input  logic                      sched_abort,
  output logic                      start_rd,
  output logic                      cfg_ready,
  output logic [ROM_ADDR_WIDTH-1:0] cfg_dma_base_addr,
  output logic [ROM_ADDR_WIDTH-1:0] cfg_dma_num_bytes,
  input  logic                      batch_dma_done,
  output logic                      sched_busy,
  output logic                      sched_done,
  output logic [DESC_IDX_W-1:0]     sched_batch_idx,
  output logic                      sched_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CFG   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [DESC_IDX_W:0] NUM_DESC_C = (DESC_IDX_W+1)'(NUM_DESC);

  state_e                    state_q, state_d;
  logic [DESC_IDX_W-1:0]     idx_q, idx_d;
  logic [DESC_IDX_W:0]       num_q, num_d;
  logic [DESC_IDX_W:0]       idx_inc;
  logic                      abort_pend_q, abort_pend_d;
  logic [ROM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [ROM_ADDR_WIDTH-1:0] len_q, len_d;
  logic                      cfg_ready_q, cfg_ready_d;
  logic                      start_rd_q, start_rd_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [ROM_ADDR_WIDTH-1:0] desc_base_q [NUM_DESC];
  logic [ROM_ADDR_WIDTH-1:0] desc_base_d [NUM_DESC];
  logic [ROM_ADDR_WIDTH-1:0] desc_len_q  [NUM_DESC];
  logic [ROM_ADDR_WIDTH-1:0] desc_len_d  [NUM_DESC];
  logic                      timeout_hit;

  assign idx_inc = {1'b0, idx_q} + {{DESC_IDX_W{1'b0}}, 1'b1};

  // Next-state, descriptor table update and registered-output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    abort_pend_d = abort_pend_q;
    base_d       = base_q;
    len_d        = len_q;
    desc_base_d  = desc_base_q;
    desc_len_d   = desc_len_q;

    if (state_q == S_IDLE && desc_wr_en) begin
      desc_base_d[desc_wr_idx] = desc_wr_base;
      desc_len_d[desc_wr_idx]  = desc_wr_len;
    end else begin
      desc_base_d = desc_base_q;
    end

    case (state_q)
      S_IDLE: begin
        if (sched_start) begin
          num_d        = (sched_num_batches > NUM_DESC_C) ? NUM_DESC_C : sched_num_batches;
          idx_d        = '0;
          abort_pend_d = 1'b0;
          state_d      = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      // An empty run still passes through LOAD so sched_done lands two cycles after start
      S_LOAD: begin
        if (sched_abort || num_q == '0) begin
          state_d = S_DONE;
        end else if (desc_len_q[idx_q] == '0) begin
          state_d = S_NEXT;
        end else begin
          base_d  = desc_base_q[idx_q];
          len_d   = desc_len_q[idx_q];
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        state_d = sched_abort ? S_DONE : S_START;
      end
      S_START: begin
        if (sched_abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sched_abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        if (batch_dma_done) begin
          state_d = S_NEXT;
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_NEXT: begin
        if (idx_inc == num_q || abort_pend_q || sched_abort) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_inc[DESC_IDX_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cfg_ready_d = (state_d == S_CFG);
    start_rd_d  = (state_d == S_START);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // Control state, cfg outputs and descriptor table registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      abort_pend_q <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      cfg_ready_q  <= 1'b0;
      start_rd_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NUM_DESC; i++) begin
        desc_base_q[i] <= '0;
        desc_len_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      abort_pend_q <= abort_pend_d;
      base_q       <= base_d;
      len_q        <= len_d;
      cfg_ready_q  <= cfg_ready_d;
      start_rd_q   <= start_rd_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      desc_base_q  <= desc_base_d;
      desc_len_q   <= desc_len_d;
    end
  end

`ifdef ROM_DMA_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles only; it is zero whenever WAIT is entered
  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q;
    if (state_q == S_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end
    if (state_q == S_IDLE && sched_start) begin
      err_d = 1'b0;
    end else if (state_q == S_WAIT && !batch_dma_done && timeout_hit) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign sched_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign sched_err   = 1'b0;
`endif

  assign start_rd          = start_rd_q;
  assign cfg_ready         = cfg_ready_q;
  assign cfg_dma_base_addr = base_q;
  assign cfg_dma_num_bytes = len_q;
  assign sched_busy        = busy_q;
  assign sched_done        = done_q;
  assign sched_batch_idx   = idx_q;

endmodule

// File: tb/tb_rom_dma_batch_sched.sv
// Directed self-checking bench for rom_dma_batch_sched (optionally with ROM_DMA_SCHED_TIMEOUT_EN).
module tb_rom_dma_batch_sched;

`ifdef ROM_DMA_SCHED_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        desc_wr_en;
  logic [2:0]  desc_wr_idx;
  logic [15:0] desc_wr_base;
  logic [15:0] desc_wr_len;
  logic        sched_start;
  logic [3:0]  sched_num_batches;
  logic        sched_abort;
  logic        start_rd;
  logic        cfg_ready;
  logic [15:0] cfg_dma_base_addr;
  logic [15:0] cfg_dma_num_bytes;
  logic        batch_dma_done;
  logic        sched_busy;
  logic        sched_done;
  logic [2:0]  sched_batch_idx;
  logic        sched_err;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_cfg = 0;
  int s0, c0;
  bit got;

  rom_dma_batch_sched #(
    .ROM_ADDR_WIDTH(16),
    .NUM_DESC(8),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .desc_wr_en(desc_wr_en),
    .desc_wr_idx(desc_wr_idx),
    .desc_wr_base(desc_wr_base),
    .desc_wr_len(desc_wr_len),
    .sched_start(sched_start),
    .sched_num_batches(sched_num_batches),
    .sched_abort(sched_abort),
    .start_rd(start_rd),
    .cfg_ready(cfg_ready),
    .cfg_dma_base_addr(cfg_dma_base_addr),
    .cfg_dma_num_bytes(cfg_dma_num_bytes),
    .batch_dma_done(batch_dma_done),
    .sched_busy(sched_busy),
    .sched_done(sched_done),
    .sched_batch_idx(sched_batch_idx),
    .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (start_rd) n_start++;
    if (cfg_ready) n_cfg++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_desc(input logic [2:0] idx, input logic [15:0] base, input logic [15:0] len);
    desc_wr_en   = 1'b1;
    desc_wr_idx  = idx;
    desc_wr_base = base;
    desc_wr_len  = len;
    tick();
    desc_wr_en   = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] num);
    sched_num_batches = num;
    sched_start       = 1'b1;
    tick();
    sched_start       = 1'b0;
  endtask

  // Acts as rom_dma_ctrl: answers every start_rd with a done pulse in the first WAIT cycle
  task automatic serve(input int budget, output bit got_done);
    bit fire;
    fire = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      batch_dma_done = fire;
      fire = start_rd;
      if (sched_done) begin
        got_done = 1'b1;
        break;
      end
    end
    batch_dma_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    desc_wr_en = 1'b0; desc_wr_idx = 3'd0; desc_wr_base = 16'h0; desc_wr_len = 16'h0;
    sched_start = 1'b0; sched_num_batches = 4'd0; sched_abort = 1'b0; batch_dma_done = 1'b0;
    #1;
    check("rst_busy", sched_busy, 1'b0);
    check("rst_start_rd", start_rd, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_done", sched_done, 1'b0);
    check("rst_idx", sched_batch_idx, 3'd0);
    check("rst_err", sched_err, 1'b0);
    check("rst_base", cfg_dma_base_addr, 16'h0);
    check("rst_len", cfg_dma_num_bytes, 16'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single batch: latency and cfg values
    wr_desc(3'd0, 16'h0100, 16'd16);
    sched_num_batches = 4'd1;
    sched_start = 1'b1;
    check("t0_busy", sched_busy, 1'b0);
    tick(); sched_start = 1'b0;
    check("t1_busy", sched_busy, 1'b1);
    check("t1_cfg_ready", cfg_ready, 1'b0);
    tick();
    check("t2_cfg_ready", cfg_ready, 1'b1);
    check("t2_base", cfg_dma_base_addr, 16'h0100);
    check("t2_len", cfg_dma_num_bytes, 16'd16);
    check("t2_start_rd", start_rd, 1'b0);
    tick();
    check("t3_start_rd", start_rd, 1'b1);
    check("t3_cfg_ready", cfg_ready, 1'b0);
    tick(); tick();
    check("wait_start_rd", start_rd, 1'b0);
    check("wait_done", sched_done, 1'b0);
    batch_dma_done = 1'b1; tick(); batch_dma_done = 1'b0;
    check("next_done", sched_done, 1'b0);
    tick();
    check("single_done", sched_done, 1'b1);
    check("single_idx", sched_batch_idx, 3'd0);
    tick();
    check("single_idle_done", sched_done, 1'b0);
    check("single_idle_busy", sched_busy, 1'b0);
    check("single_base_held", cfg_dma_base_addr, 16'h0100);

    // Zero-length entry is skipped
    wr_desc(3'd0, 16'h0000, 16'd4);
    wr_desc(3'd1, 16'h0040, 16'd0);
    wr_desc(3'd2, 16'h0080, 16'd8);
    s0 = n_start; c0 = n_cfg;
    start_run(4'd3);
    serve(100, got);
    check("skip_got_done", got, 1'b1);
    check("skip_starts", n_start - s0, 2);
    check("skip_cfgs", n_cfg - c0, 2);
    check("skip_idx", sched_batch_idx, 3'd2);
    check("skip_base", cfg_dma_base_addr, 16'h0080);
    check("skip_len", cfg_dma_num_bytes, 16'd8);
    tick();

    // Empty run
    s0 = n_start; c0 = n_cfg;
    start_run(4'd0);
    check("zero_t1_done", sched_done, 1'b0);
    check("zero_t1_busy", sched_busy, 1'b1);
    tick();
    check("zero_t2_done", sched_done, 1'b1);
    tick();
    check("zero_idle_busy", sched_busy, 1'b0);
    check("zero_no_cfg", n_cfg - c0, 0);
    check("zero_no_start", n_start - s0, 0);

    // Abort during WAIT of batch 0 of 4
    wr_desc(3'd1, 16'h0200, 16'd32);
    wr_desc(3'd3, 16'h0300, 16'd12);
    s0 = n_start;
    start_run(4'd4);
    tick(); tick();
    check("abort_start_rd", start_rd, 1'b1);
    tick();
    sched_abort = 1'b1; tick(); sched_abort = 1'b0;
    tick();
    check("abort_wait_busy", sched_busy, 1'b1);
    check("abort_wait_done", sched_done, 1'b0);
    batch_dma_done = 1'b1; tick(); batch_dma_done = 1'b0;
    check("abort_next_done", sched_done, 1'b0);
    tick();
    check("abort_done", sched_done, 1'b1);
    check("abort_idx", sched_batch_idx, 3'd0);
    repeat (4) tick();
    check("abort_one_start", n_start - s0, 1);
    check("abort_idle", sched_busy, 1'b0);

    // Table write and start while busy are dropped
    s0 = n_start;
    start_run(4'd1);
    repeat (3) tick();
    desc_wr_en = 1'b1; desc_wr_idx = 3'd0; desc_wr_base = 16'hDEAD; desc_wr_len = 16'h0055;
    sched_start = 1'b1; sched_num_batches = 4'd2;
    tick();
    desc_wr_en = 1'b0; sched_start = 1'b0;
    batch_dma_done = 1'b1; tick(); batch_dma_done = 1'b0;
    tick();
    check("busy_run_done", sched_done, 1'b1);
    check("busy_run_idx", sched_batch_idx, 3'd0);
    tick();
    check("busy_run_idle", sched_busy, 1'b0);
    start_run(4'd1);
    tick();
    check("busy_tbl_base", cfg_dma_base_addr, 16'h0000);
    check("busy_tbl_len", cfg_dma_num_bytes, 16'd4);
    serve(20, got);
    check("busy_rerun_done", got, 1'b1);
    check("busy_starts", n_start - s0, 2);
    tick();

    // Count above NUM_DESC clamps to 8 entries (4..7 still empty)
    s0 = n_start;
    start_run(4'd15);
    serve(300, got);
    check("clamp_got_done", got, 1'b1);
    check("clamp_starts", n_start - s0, 4);
    check("clamp_idx", sched_batch_idx, 3'd7);
    tick();

`ifdef ROM_DMA_SCHED_TIMEOUT_EN
    // Watchdog: no batch_dma_done
    start_run(4'd1);
    tick(); tick();
    check("to_start_rd", start_rd, 1'b1);
    repeat (16) tick();
    check("to_not_yet", sched_done, 1'b0);
    tick();
    check("to_done", sched_done, 1'b1);
    check("to_err", sched_err, 1'b1);
    tick();
    check("to_err_sticky", sched_err, 1'b1);
    start_run(4'd1);
    check("to_err_clear", sched_err, 1'b0);
    serve(20, got);
    check("to_rerun_done", got, 1'b1);
    tick();
`else
    check("no_to_err", sched_err, 1'b0);
`endif

    // Asynchronous reset while waiting
    wr_desc(3'd0, 16'h0100, 16'd16);
    start_run(4'd1);
    repeat (3) tick();
    check("rst_wait_busy", sched_busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", sched_busy, 1'b0);
    check("arst_base", cfg_dma_base_addr, 16'h0);
    check("arst_len", cfg_dma_num_bytes, 16'h0);
    check("arst_start_rd", start_rd, 1'b0);
    check("arst_done", sched_done, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    c0 = n_cfg;
    start_run(4'd1);
    repeat (4) tick();
    check("arst_table_cleared", n_cfg - c0, 0);
    check("arst_rerun_idle", sched_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
